// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: data width, FSM state
// encoding and a width helper.
package fifo_pkg;
  localparam int FIFO_DW = 16;

  typedef enum logic {IDLE, BURST} state_t;

  // ceil(log2(v)), never below 1 so one-entry ranges still get a bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate requests so last+1 sits at bit 0, take the first
// set bit, then map the position back to a requester index.
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          any
);
  logic [N-1:0]  rot;
  logic [IW-1:0] idx;
  logic          found;
  int            start;
  int            pos;

  always_comb begin
    rot   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    start = (int'(last) + 1) % N;
    for (int i = 0; i < N; i++) begin
      idx    = IW'((start + i) % N);
      rot[i] = req[idx];
    end
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    winner = IW'((start + pos) % N);
    any    = |req;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among N valid/ready producers with round-robin
// grants limited to MAX_BURST beats each.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int DW        = FIFO_DW,
  parameter  int MAX_BURST = 4,
  localparam int IW        = clog2(N),
  localparam int BW        = clog2(MAX_BURST + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            fifo_full,
  output logic            fifo_w_en,
  output logic [DW-1:0]   fifo_data_in,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);
  state_t                 state, state_nx;
  logic [IW-1:0]          last, last_nx, grant_nx;
  logic [BW-1:0]          beat_cnt, beat_nx;
  logic [IW-1:0]          pick_id;
  logic                   pick_any;
  logic [N-1:0][DW-1:0]   data_arr;

  assign data_arr = req_data;

  rr_pick #(.N(N)) u_pick (
    .req    (req_valid),
    .last   (last),
    .winner (pick_id),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= IW'(N - 1);
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      last     <= last_nx;
      beat_cnt <= beat_nx;
      busy     <= (state_nx == BURST);
    end
  end

  always_comb begin
    state_nx     = state;
    grant_nx     = grant_id;
    last_nx      = last;
    beat_nx      = beat_cnt;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nx = pick_id;
          last_nx  = pick_id;
          beat_nx  = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id] = !fifo_full;
        fifo_data_in        = data_arr[grant_id];
        fifo_w_en           = req_valid[grant_id] & !fifo_full;
        // a stall with valid held keeps the grant and the count untouched
        if (!req_valid[grant_id]) begin
          state_nx = IDLE;
        end else if (fifo_w_en) begin
          beat_nx = beat_cnt + 1'b1;
          if (beat_cnt == BW'(MAX_BURST - 1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
